// File: rtl/t01_lineclear_pkg.sv
// Shared types and helpers for the row compactor: FSM states, default
// geometry/score constants, and the line-count to base-score mapping.
package t01_lineclear_pkg;

    localparam int DEF_COLS      = 10;
    localparam int DEF_ROWS      = 20;
    localparam int DEF_COLOR_W   = 3;
    localparam int DEF_LEVEL_W   = 4;
    localparam int DEF_SCORE_W   = 10;
    localparam int DEF_SCORE_MAX = 999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMPACT,
        ST_SCORE,
        ST_DONE
    } state_t;

    // Anything beyond four rows scores like four.
    function automatic logic [3:0] base_score(input logic [15:0] n);
        case (n)
            16'd0:   base_score = 4'd0;
            16'd1:   base_score = 4'd1;
            16'd2:   base_score = 4'd3;
            16'd3:   base_score = 4'd5;
            default: base_score = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/t01_score_calc.sv
// Combinational score update: base(lines) * (level + 1) added to the
// current score, saturating at SCORE_MAX.
module t01_score_calc
    import t01_lineclear_pkg::*;
#(
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int LEVEL_W   = DEF_LEVEL_W,
    parameter int CNT_W     = 5,
    parameter int SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic [SCORE_W-1:0] score_cur,
    input  logic [CNT_W-1:0]   lines,
    input  logic [LEVEL_W-1:0] level,
    output logic [SCORE_W-1:0] score_next
);

    // Wide enough that neither the product nor the sum can wrap.
    localparam int WW = SCORE_W + LEVEL_W + 4;

    logic [WW-1:0] inc;
    logic [WW-1:0] sum;

    always_comb begin
        inc = WW'(base_score(16'(lines))) * (WW'(level) + WW'(1));
        sum = WW'(score_cur) + inc;
        if (sum > WW'(SCORE_MAX)) begin
            score_next = SCORE_W'(SCORE_MAX);
        end else begin
            score_next = sum[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/t01_row_compactor.sv
// Full-row detector and board compactor: scans for full rows, packs the
// surviving rows toward the bottom with a rd/wr row pointer pass, scores.
module t01_row_compactor
    import t01_lineclear_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int LEVEL_W   = DEF_LEVEL_W,
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int SCORE_MAX = DEF_SCORE_MAX,
    parameter int CNT_W     = $clog2(ROWS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          start,
    input  logic [LEVEL_W-1:0]            level,
    input  logic [ROWS*COLS-1:0]          board_in,
    input  logic [ROWS*COLS*COLOR_W-1:0]  color_in,
    output logic [ROWS*COLS-1:0]          board_out,
    output logic [ROWS*COLS*COLOR_W-1:0]  color_out,
    output logic [ROWS-1:0]               full_mask,
    output logic [CNT_W-1:0]              lines_cleared,
    output logic [SCORE_W-1:0]            score,
    output logic                          busy,
    output logic                          done
);

    // Handshake: start is sampled only in IDLE (clear has priority); busy is
    // high from the cycle after acceptance until the cycle after done; done
    // pulses for one cycle once board, mask, count and score are final.

    localparam int PW  = $clog2(ROWS);
    localparam int RW  = COLS * COLOR_W;
    localparam int BIW = $clog2(ROWS * COLS);
    localparam int CIW = $clog2(ROWS * COLS * COLOR_W);

    state_t                         state_q, state_d;
    logic [ROWS*COLS-1:0]           board_q;
    logic [ROWS*COLS*COLOR_W-1:0]   color_q;
    logic [ROWS-1:0]                mask_q;
    logic [CNT_W-1:0]               lines_q;
    logic [SCORE_W-1:0]             score_q;
    logic [SCORE_W-1:0]             score_next;
    logic [LEVEL_W-1:0]             level_q;
    logic [PW-1:0]                  rd_q;
    logic [PW-1:0]                  wr_q;

    logic [BIW-1:0]                 rd_boff, wr_boff;
    logic [CIW-1:0]                 rd_coff, wr_coff;
    logic                           row_full;

    assign rd_boff  = BIW'(rd_q) * BIW'(COLS);
    assign wr_boff  = BIW'(wr_q) * BIW'(COLS);
    assign rd_coff  = CIW'(rd_q) * CIW'(RW);
    assign wr_coff  = CIW'(wr_q) * CIW'(RW);
    assign row_full = &board_q[rd_boff +: COLS];

    t01_score_calc #(
        .SCORE_W   (SCORE_W),
        .LEVEL_W   (LEVEL_W),
        .CNT_W     (CNT_W),
        .SCORE_MAX (SCORE_MAX)
    ) u_score_calc (
        .score_cur  (score_q),
        .lines      (lines_q),
        .level      (level_q),
        .score_next (score_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_SCAN;
            ST_SCAN:    if (rd_q == '0) state_d = ST_COMPACT;
            ST_COMPACT: if (rd_q == '0) state_d = ST_SCORE;
            ST_SCORE:   state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            color_q <= '0;
            mask_q  <= '0;
            lines_q <= '0;
            score_q <= '0;
            level_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            color_q <= '0;
            mask_q  <= '0;
            lines_q <= '0;
            score_q <= '0;
            level_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        board_q <= board_in;
                        color_q <= color_in;
                        level_q <= level;
                        mask_q  <= '0;
                        lines_q <= '0;
                        rd_q    <= PW'(ROWS - 1);
                    end
                end
                ST_SCAN: begin
                    if (row_full) begin
                        mask_q[rd_q] <= 1'b1;
                        lines_q      <= lines_q + CNT_W'(1);
                    end
                    if (rd_q == '0) begin
                        rd_q <= PW'(ROWS - 1);
                        wr_q <= PW'(ROWS - 1);
                    end else begin
                        rd_q <= rd_q - PW'(1);
                    end
                end
                ST_COMPACT: begin
                    // The row just read is vacated; a surviving row's copy to
                    // wr (wr >= rd) overrides it, so rows above the packed
                    // stack end up zero after the pass.
                    board_q[rd_boff +: COLS] <= '0;
                    color_q[rd_coff +: RW]   <= '0;
                    if (!mask_q[rd_q]) begin
                        board_q[wr_boff +: COLS] <= board_q[rd_boff +: COLS];
                        color_q[wr_coff +: RW]   <= color_q[rd_coff +: RW];
                        wr_q                     <= wr_q - PW'(1);
                    end
                    if (rd_q != '0) rd_q <= rd_q - PW'(1);
                end
                ST_SCORE: begin
                    score_q <= score_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign board_out     = board_q;
    assign color_out     = color_q;
    assign full_mask     = mask_q;
    assign lines_cleared = lines_q;
    assign score         = score_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

endmodule
